// File: rtl/piso_shift.sv
// Parallel-in serial-out converter: takes one WIDTH-bit word per valid/ready
// handshake and emits it one bit per clock, streaming back-to-back words seamlessly.
module piso_shift #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [0:0]      ST_IDLE  = 1'b0;
  localparam logic [0:0]      ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_shifted;
  logic             out_bit;
  logic             in_shift;
  logic             last_bit;
  logic             fire;

  // Bit order only changes which end of shreg drains and which way it moves.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
      assign out_bit       = shreg_q[WIDTH-1];
    end else begin : g_lsb_first
      assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
      assign out_bit       = shreg_q[0];
    end
  endgenerate

  assign in_shift   = (state_q == ST_SHIFT);
  assign last_bit   = in_shift && (cnt_q == CNT_LAST);
  assign load_ready = (state_q == ST_IDLE) || last_bit;
  assign fire       = load_valid && load_ready;

  assign sout       = in_shift && out_bit;
  assign sout_valid = in_shift;
  assign busy       = in_shift;
  assign done       = last_bit;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          shreg_d = d;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      default: begin
        if (last_bit) begin
          cnt_d = '0;
          // A word accepted on the last bit keeps the stream gap-free.
          if (fire) begin
            shreg_d = d;
          end else begin
            shreg_d = shreg_shifted;
            state_d = ST_IDLE;
          end
        end else begin
          shreg_d = shreg_shifted;
          cnt_d   = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_shift.sv
// Scoreboard bench for piso_shift: three instances (4-bit MSB-first, 4-bit LSB-first,
// 8-bit MSB-first) checked against a word-level model of the serial stream.
module tb_piso_shift;

  localparam int W_OF   [3] = '{4, 4, 8};
  localparam bit MSB_OF [3] = '{1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d_v [3];
  logic [2:0] lv = '0;
  logic [2:0] lr, so, sv, bz, dn;

  int rem [3];
  bit hs  [3];
  int wp  [3];
  int rp  [3];
  bit exp_bit [3][1024];
  bit exp_dn  [3][1024];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piso_shift #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb4 (
    .clk(clk), .rst_n(rst_n), .d(d_v[0][3:0]), .load_valid(lv[0]), .load_ready(lr[0]),
    .sout(so[0]), .sout_valid(sv[0]), .busy(bz[0]), .done(dn[0]));
  piso_shift #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb4 (
    .clk(clk), .rst_n(rst_n), .d(d_v[1][3:0]), .load_valid(lv[1]), .load_ready(lr[1]),
    .sout(so[1]), .sout_valid(sv[1]), .busy(bz[1]), .done(dn[1]));
  piso_shift #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
    .clk(clk), .rst_n(rst_n), .d(d_v[2]), .load_valid(lv[2]), .load_ready(lr[2]),
    .sout(so[2]), .sout_valid(sv[2]), .busy(bz[2]), .done(dn[2]));

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", nm, i, $time, act, exp);
    end
  endtask

  // Reference model: a word accepted when at most one bit remains queues its bits in wire order.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        rem[i] = 0;
        hs[i]  = 1'b0;
        wp[i]  = rp[i];
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit acc;
        hs[i] = 1'b0;
        acc   = lv[i] && (rem[i] <= 1);
        if (rem[i] > 0) rem[i]--;
        if (acc) begin
          hs[i] = 1'b1;
          $display("dut%0d load word %0h", i, d_v[i] & 8'((1 << W_OF[i]) - 1));
          for (int b = 0; b < W_OF[i]; b++) begin
            exp_bit[i][wp[i] & 1023] = MSB_OF[i] ? d_v[i][W_OF[i]-1-b] : d_v[i][b];
            exp_dn[i][wp[i] & 1023]  = (b == W_OF[i] - 1);
            wp[i]++;
          end
          rem[i] = W_OF[i];
        end
      end
    end
  end

  // Monitor: pops one expected bit whenever a DUT presents sout_valid.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        chk("rst_load_ready", i, 32'(lr[i]), 32'd1);
        chk("rst_sout_valid", i, 32'(sv[i]), 32'd0);
        chk("rst_busy", i, 32'(bz[i]), 32'd0);
        chk("rst_done", i, 32'(dn[i]), 32'd0);
        chk("rst_sout", i, 32'(so[i]), 32'd0);
      end else begin
        chk("load_ready", i, 32'(lr[i]), 32'(rem[i] <= 1));
        chk("sout_valid", i, 32'(sv[i]), 32'(rem[i] > 0));
        chk("busy", i, 32'(bz[i]), 32'(rem[i] > 0));
        chk("done", i, 32'(dn[i]), 32'(rem[i] == 1));
        if (sv[i]) begin
          chk("queue_nonempty", i, 32'(wp[i] != rp[i]), 32'd1);
          if (wp[i] != rp[i]) begin
            chk("sout_bit", i, 32'(so[i]), 32'(exp_bit[i][rp[i] & 1023]));
            chk("done_on_last", i, 32'(dn[i]), 32'(exp_dn[i][rp[i] & 1023]));
            rp[i]++;
          end
        end else begin
          chk("sout_idle", i, 32'(so[i]), 32'd0);
        end
      end
    end
  end

  // Presents a word and holds it until the model reports a handshake.
  task automatic load(input int i, input logic [7:0] w, input bit keep);
    bit ok = 1'b0;
    d_v[i] = w;
    lv[i]  = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (hs[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL handshake_timeout dut%0d: no handshake for word %0h", i, w);
    end
    if (!keep) lv[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (rem[0] == 0 && rem[1] == 0 && rem[2] == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: model still shifting");
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      d_v[i] = '0;
      rem[i] = 0;
      wp[i]  = 0;
      rp[i]  = 0;
    end
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    load(0, 8'h0B, 1'b0);
    wait_idle();
    load(0, 8'h05, 1'b1);
    load(0, 8'h0A, 1'b0);
    wait_idle();
    load(0, 8'h0C, 1'b0);
    @(negedge clk);
    load(0, 8'h0F, 1'b0);
    wait_idle();
    load(1, 8'h0D, 1'b0);
    wait_idle();

    load(0, 8'h03, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("async_rst_sout_valid", i, 32'(sv[i]), 32'd0);
      chk("async_rst_busy", i, 32'(bz[i]), 32'd0);
      chk("async_rst_done", i, 32'(dn[i]), 32'd0);
      chk("async_rst_sout", i, 32'(so[i]), 32'd0);
      chk("async_rst_load_ready", i, 32'(lr[i]), 32'd1);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    load(0, 8'h0C, 1'b0);
    wait_idle();
    load(2, 8'hA5, 1'b0);
    wait_idle();

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (lv[i] && hs[i]) begin
          if ($urandom_range(0, 1) == 1) d_v[i] = 8'($urandom);
          else lv[i] = 1'b0;
        end else if (!lv[i] && $urandom_range(0, 2) == 0) begin
          d_v[i] = 8'($urandom);
          lv[i]  = 1'b1;
        end
      end
    end
    @(negedge clk);
    lv = '0;
    wait_idle();
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("queue_drained", i, 32'(wp[i] - rp[i]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
